data_memory_responder: RTL and testbench

- Single-port word-organised data memory that acts as the responder end of the core's data-memory request/response interface.
- Accepts one request at a time (valid, address, function, mask type, write data) from the memory stage and performs a byte-, half- or word-granular read or write.
- Returns a registered response with sign/zero extension, asserting a stall while the request must be held.
- Sits beside the pipeline as the data-memory model for simulation and as the on-chip scratchpad for FPGA builds.

---
 rtl/data_memory_responder.sv | 171 +++++++++++++++++
 tb/tb_data_memory_responder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_memory_responder                                                      |
// | Single-port word-organised data memory answering the core's data-memory   |
// | request/response interface with optional wait states.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

package Bundle;
  typedef enum logic [0:0] {M_XRD = 1'b0, M_XWR = 1'b1} MemoryWriteSignal;
  typedef enum logic [2:0] {
    MT_X  = 3'd0,
    MT_B  = 3'd1,
    MT_H  = 3'd2,
    MT_W  = 3'd3,
    MT_BU = 3'd4,
    MT_HU = 3'd5
  } MemoryMaskType;
endpackage

module data_memory_responder #(
  parameter int DEPTH_WORDS = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic [31:0]              req_addr,
  input  Bundle::MemoryWriteSignal req_fcn,
  input  Bundle::MemoryMaskType    req_typ,
  input  logic [31:0]              req_data,
  output logic                     stall,
  output logic                     res_valid,
  output logic [31:0]              res_data,
  output logic                     res_misaligned
);

  localparam int         c_aw   = $clog2(DEPTH_WORDS);
  localparam logic [3:0] c_wait = 4'(WAIT_STATES);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t                   r_state, w_state_nxt;
  logic [3:0]               r_cnt, w_cnt_nxt;
  logic [31:0]              r_addr, r_data;
  Bundle::MemoryWriteSignal r_fcn;
  Bundle::MemoryMaskType    r_typ;

  logic                     w_latch, w_fire, w_from_wait;
  logic [31:0]              w_addr, w_wdata;
  Bundle::MemoryWriteSignal w_fcn;
  Bundle::MemoryMaskType    w_typ;
  logic                     w_is_wr, w_mis;
  logic [c_aw-1:0]          w_idx;
  logic [1:0]               w_off;
  logic [3:0]               w_be;
  logic [31:0]              w_lane, w_word, w_shift, w_rdata;
  logic                     w_unused_addr;

  logic [31:0] mem [DEPTH_WORDS];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_fire      = 1'b0;
    w_from_wait = 1'b0;
    stall       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (c_wait == 4'd0) begin
            w_fire = 1'b1;
          end else begin
            stall       = 1'b1;
            w_latch     = 1'b1;
            w_cnt_nxt   = c_wait;
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        stall     = 1'b1;
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_fire      = 1'b1;
          w_from_wait = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Reset drops the held request immediately, so the requester is released too.
    if (reset) stall = 1'b0;
  end

  always_comb begin
    w_addr  = w_from_wait ? r_addr : req_addr;
    w_fcn   = w_from_wait ? r_fcn  : req_fcn;
    w_typ   = w_from_wait ? r_typ  : req_typ;
    w_wdata = w_from_wait ? r_data : req_data;
    w_is_wr = (w_fcn == Bundle::M_XWR);
    w_idx   = w_addr[c_aw+1:2];
    w_off   = w_addr[1:0];
    w_mis   = 1'b0;
    w_be    = 4'b1111;
    w_lane  = w_wdata;
    case (w_typ)
      Bundle::MT_B, Bundle::MT_BU: begin
        w_be   = 4'b0001 << w_off;
        w_lane = {4{w_wdata[7:0]}};
      end
      Bundle::MT_H, Bundle::MT_HU: begin
        w_mis  = w_off[0];
        w_be   = w_off[1] ? 4'b1100 : 4'b0011;
        w_lane = {2{w_wdata[15:0]}};
      end
      default: w_mis = (w_off != 2'b00);
    endcase
    w_word  = mem[w_idx];
    w_shift = w_word >> {w_off, 3'b000};
    w_rdata = w_word;
    case (w_typ)
      Bundle::MT_B:  w_rdata = {{24{w_shift[7]}}, w_shift[7:0]};
      Bundle::MT_BU: w_rdata = {24'd0, w_shift[7:0]};
      Bundle::MT_H:  w_rdata = {{16{w_shift[15]}}, w_shift[15:0]};
      Bundle::MT_HU: w_rdata = {16'd0, w_shift[15:0]};
      default:       w_rdata = w_word;
    endcase
  end

  assign w_unused_addr = ^w_addr[31:c_aw+2];

  // Contents are deliberately not reset; a reset edge still blocks the write.
  always_ff @(posedge clk) begin
    if (!reset && w_fire && w_is_wr && !w_mis) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) mem[w_idx][8*i +: 8] <= w_lane[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= 4'd0;
      r_addr         <= 32'd0;
      r_data         <= 32'd0;
      r_fcn          <= Bundle::M_XRD;
      r_typ          <= Bundle::MT_X;
      res_valid      <= 1'b0;
      res_data       <= 32'd0;
      res_misaligned <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_latch) begin
        r_addr <= req_addr;
        r_data <= req_data;
        r_fcn  <= req_fcn;
        r_typ  <= req_typ;
      end
      res_valid      <= w_fire;
      res_misaligned <= w_fire & w_mis;
      res_data       <= (w_fire && !w_is_wr && !w_mis) ? w_rdata : 32'd0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_data_memory_responder                                                   |
// | Self-checking bench: three instances with 0, 2 and 3 wait states.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module tb_data_memory_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst_v;
  logic [2:0]       req_valid;
  logic [2:0]       req_fcn;
  logic [2:0][2:0]  req_typ;
  logic [2:0][31:0] req_addr;
  logic [2:0][31:0] req_data;
  wire  [2:0]       stall;
  wire  [2:0]       res_valid;
  wire  [2:0]       res_mis;
  wire  [2:0][31:0] res_data;

  int n_cmp = 0;
  int n_err = 0;

  // Byte-addressed reference image per instance (16 KiB wrap).
  bit [7:0] mm [3][16384];

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      data_memory_responder #(
        .DEPTH_WORDS(4096),
        .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 2 : 3))
      ) u_dut (
        .clk           (clk),
        .reset         (rst_v[g]),
        .req_valid     (req_valid[g]),
        .req_addr      (req_addr[g]),
        .req_fcn       (Bundle::MemoryWriteSignal'(req_fcn[g])),
        .req_typ       (Bundle::MemoryMaskType'(req_typ[g])),
        .req_data      (req_data[g]),
        .stall         (stall[g]),
        .res_valid     (res_valid[g]),
        .res_data      (res_data[g]),
        .res_misaligned(res_mis[g])
      );
    end
  endgenerate

  task automatic model(input int k, input bit wr, input logic [2:0] typ,
                       input logic [31:0] addr, input logic [31:0] data,
                       output logic [31:0] exp_d, output bit exp_m);
    int size;
    int base;
    bit sgn;
    logic [31:0] v;
    base = int'(addr % 32'd16384);
    if (typ == Bundle::MT_B || typ == Bundle::MT_BU) size = 1;
    else if (typ == Bundle::MT_H || typ == Bundle::MT_HU) size = 2;
    else size = 4;
    sgn   = (typ == Bundle::MT_B || typ == Bundle::MT_H);
    exp_m = (base % size) != 0;
    exp_d = 32'd0;
    if (!exp_m) begin
      if (wr) begin
        for (int i = 0; i < size; i++) mm[k][base+i] = 8'(data >> (8*i));
      end else begin
        v = 32'd0;
        for (int i = 0; i < size; i++) v = v | (32'(mm[k][base+i]) << (8*i));
        if (sgn && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
        exp_d = v;
      end
    end
  endtask

  // Issues one request for a single cycle, then waits (bounded) for its response.
  task automatic access(input int k, input bit wr, input logic [2:0] typ,
                        input logic [31:0] addr, input logic [31:0] data,
                        input bit garbage, output bit got, output logic [31:0] rdata,
                        output bit mis, output int lat, output int nstall);
    got = 0; rdata = 32'd0; mis = 0; lat = -1; nstall = 0;
    @(posedge clk); #1;
    req_valid[k] = 1'b1; req_fcn[k] = wr; req_typ[k] = typ;
    req_addr[k] = addr; req_data[k] = data;
    @(negedge clk);
    if (stall[k]) nstall++;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    if (garbage) begin
      req_valid[k] = 1'b1; req_fcn[k] = 1'b1; req_typ[k] = 3'($urandom_range(0, 5));
      req_addr[k] = $urandom; req_data[k] = $urandom;
    end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (res_valid[k]) begin
        got = 1; rdata = res_data[k]; mis = res_mis[k]; lat = c;
        break;
      end
      if (stall[k]) nstall++;
      @(posedge clk); #1;
      req_valid[k] = 1'b0;
    end
    req_valid[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst_v = 3'b111; req_valid = 3'b000; req_fcn = 3'b000;
    req_typ = '0; req_addr = '0; req_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (stall[k] !== 1'b0) begin n_err++; $display("FAIL reset_stall[%0d]: got %b expected 0", k, stall[k]); end
      n_cmp++; if (res_valid[k] !== 1'b0) begin n_err++; $display("FAIL reset_valid[%0d]: got %b expected 0", k, res_valid[k]); end
      n_cmp++; if (res_data[k] !== 32'd0) begin n_err++; $display("FAIL reset_data[%0d]: got %h expected 0", k, res_data[k]); end
      n_cmp++; if (res_mis[k] !== 1'b0) begin n_err++; $display("FAIL reset_mis[%0d]: got %b expected 0", k, res_mis[k]); end
    end
    #2 rst_v = 3'b000;
  endtask

  task automatic test_word_rw();
    bit got, mis; logic [31:0] d; int lat, ns;
    access(0, 1, Bundle::MT_W, 32'h100, 32'hDEADBEEF, 0, got, d, mis, lat, ns);
    n_cmp++; if (!got || lat != 1 || ns != 0 || d !== 32'd0 || mis) begin
      n_err++; $display("FAIL w0_write: got v=%0d lat=%0d stall=%0d d=%h m=%0d expected v=1 lat=1 stall=0 d=0 m=0", got, lat, ns, d, mis); end
    access(0, 0, Bundle::MT_W, 32'h100, 32'h0, 0, got, d, mis, lat, ns);
    n_cmp++; if (!got || lat != 1 || ns != 0 || d !== 32'hDEADBEEF || mis) begin
      n_err++; $display("FAIL w0_read: got v=%0d lat=%0d stall=%0d d=%h m=%0d expected v=1 lat=1 stall=0 d=deadbeef m=0", got, lat, ns, d, mis); end
  endtask

  task automatic test_subword();
    bit got, mis; logic [31:0] d; int lat, ns;
    logic [2:0]  t [4] = '{Bundle::MT_B, Bundle::MT_BU, Bundle::MT_H, Bundle::MT_HU};
    logic [31:0] a [4] = '{32'h103, 32'h103, 32'h102, 32'h100};
    logic [31:0] e [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
    for (int i = 0; i < 4; i++) begin
      access(0, 0, t[i], a[i], 32'h0, 0, got, d, mis, lat, ns);
      n_cmp++; if (!got || d !== e[i] || mis) begin
        n_err++; $display("FAIL subword_%0d: got v=%0d d=%h m=%0d expected v=1 d=%h m=0", i, got, d, mis, e[i]); end
    end
  endtask

  task automatic test_partial_write();
    bit got, mis; logic [31:0] d; int lat, ns;
    access(0, 1, Bundle::MT_B, 32'h101, 32'hAAAA_AA55, 0, got, d, mis, lat, ns);
    access(0, 1, Bundle::MT_H, 32'h102, 32'hBBBB_1234, 0, got, d, mis, lat, ns);
    access(0, 0, Bundle::MT_W, 32'h100, 32'h0, 0, got, d, mis, lat, ns);
    n_cmp++; if (!got || d !== 32'h123455EF) begin
      n_err++; $display("FAIL partial_write: got v=%0d d=%h expected v=1 d=123455ef", got, d); end
  endtask

  task automatic test_misaligned();
    bit got, mis; logic [31:0] d; int lat, ns;
    access(0, 1, Bundle::MT_W, 32'h102, 32'hFFFFFFFF, 0, got, d, mis, lat, ns);
    n_cmp++; if (!got || !mis || d !== 32'd0) begin
      n_err++; $display("FAIL mis_write: got v=%0d m=%0d d=%h expected v=1 m=1 d=0", got, mis, d); end
    access(0, 0, Bundle::MT_W, 32'h100, 32'h0, 0, got, d, mis, lat, ns);
    n_cmp++; if (!got || mis || d !== 32'h123455EF) begin
      n_err++; $display("FAIL mis_unchanged: got v=%0d m=%0d d=%h expected v=1 m=0 d=123455ef", got, mis, d); end
    access(0, 0, Bundle::MT_H, 32'h101, 32'h0, 0, got, d, mis, lat, ns);
    n_cmp++; if (!got || !mis || d !== 32'd0) begin
      n_err++; $display("FAIL mis_half_read: got v=%0d m=%0d d=%h expected v=1 m=1 d=0", got, mis, d); end
  endtask

  task automatic test_wrap();
    bit got, mis; logic [31:0] d; int lat, ns;
    access(0, 1, Bundle::MT_W, 32'h4000, 32'hC0FFEE11, 0, got, d, mis, lat, ns);
    access(0, 0, Bundle::MT_W, 32'h0, 32'h0, 0, got, d, mis, lat, ns);
    n_cmp++; if (!got || d !== 32'hC0FFEE11) begin
      n_err++; $display("FAIL wrap: got v=%0d d=%h expected v=1 d=c0ffee11", got, d); end
  endtask

  task automatic test_back_to_back();
    bit pv, pm, v, wr, em;
    logic [31:0] pd, addr, data, ed;
    logic [2:0] typ;
    pv = 0; pd = 0; pm = 0;
    for (int c = 0; c <= 264; c++) begin
      @(posedge clk); #1;
      if (c < 64) begin
        v = 1; wr = 1; typ = Bundle::MT_W; addr = 32'h800 + 32'(4*c);
      end else begin
        v = ($urandom_range(0, 4) != 0); wr = 1'($urandom_range(0, 1));
        typ = 3'($urandom_range(0, 5)); addr = 32'h800 + $urandom_range(0, 255);
      end
      if (c == 264) v = 0;
      data = $urandom;
      req_valid[0] = v; req_fcn[0] = wr; req_typ[0] = typ;
      req_addr[0] = addr; req_data[0] = data;
      ed = 0; em = 0;
      if (v) model(0, wr, typ, addr, data, ed, em);
      @(negedge clk);
      n_cmp++; if (stall[0] !== 1'b0) begin n_err++; $display("FAIL b2b_stall c=%0d: got %b expected 0", c, stall[0]); end
      n_cmp++; if (res_valid[0] !== pv) begin n_err++; $display("FAIL b2b_valid c=%0d: got %b expected %b", c, res_valid[0], pv); end
      if (pv) begin
        n_cmp++; if (res_data[0] !== pd || res_mis[0] !== pm) begin
          n_err++; $display("FAIL b2b_data c=%0d: got d=%h m=%b expected d=%h m=%b", c, res_data[0], res_mis[0], pd, pm); end
      end
      pv = v; pd = ed; pm = em;
    end
    req_valid[0] = 1'b0;
  endtask

  task automatic test_wait_states();
    bit got, mis; logic [31:0] d; int lat, ns;
    access(1, 1, Bundle::MT_W, 32'h100, 32'hDEADBEEF, 0, got, d, mis, lat, ns);
    n_cmp++; if (!got || lat != 3 || ns != 3 || d !== 32'd0) begin
      n_err++; $display("FAIL w2_write: got v=%0d lat=%0d stall=%0d d=%h expected v=1 lat=3 stall=3 d=0", got, lat, ns, d); end
    access(1, 0, Bundle::MT_W, 32'h100, 32'h0, 1, got, d, mis, lat, ns);
    n_cmp++; if (!got || lat != 3 || ns != 3 || d !== 32'hDEADBEEF || mis) begin
      n_err++; $display("FAIL w2_read_garbage: got v=%0d lat=%0d stall=%0d d=%h m=%0d expected v=1 lat=3 stall=3 d=deadbeef m=0", got, lat, ns, d, mis); end
  endtask

  task automatic test_overlap();
    int lat;
    @(posedge clk); #1;
    req_valid[1] = 1; req_fcn[1] = 0; req_typ[1] = Bundle::MT_W; req_addr[1] = 32'h100;
    @(posedge clk); #1; req_valid[1] = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_valid[1] = 1; req_typ[1] = Bundle::MT_HU;
    @(negedge clk);
    n_cmp++; if (res_valid[1] !== 1'b1 || stall[1] !== 1'b1 || res_data[1] !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL overlap_accept: got v=%b stall=%b d=%h expected v=1 stall=1 d=deadbeef", res_valid[1], stall[1], res_data[1]); end
    @(posedge clk); #1; req_valid[1] = 0;
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (res_valid[1]) begin lat = c; break; end
      @(posedge clk);
    end
    n_cmp++; if (lat != 3 || res_data[1] !== 32'h0000BEEF) begin
      n_err++; $display("FAIL overlap_second: got lat=%0d d=%h expected lat=3 d=0000beef", lat, res_data[1]); end
  endtask

  task automatic test_wait_random();
    bit got, mis, em, wr; logic [31:0] d, ed, addr, data; int lat, ns; logic [2:0] typ;
    for (int i = 0; i < 46; i++) begin
      if (i < 16) begin
        wr = 1; typ = Bundle::MT_W; addr = 32'h800 + 32'(4*i);
      end else begin
        wr = 1'($urandom_range(0, 1)); typ = 3'($urandom_range(0, 5));
        addr = 32'h800 + $urandom_range(0, 63);
      end
      data = $urandom;
      model(1, wr, typ, addr, data, ed, em);
      access(1, wr, typ, addr, data, 0, got, d, mis, lat, ns);
      n_cmp++; if (!got || lat != 3 || d !== ed || mis !== em) begin
        n_err++; $display("FAIL w2_random_%0d: got v=%0d lat=%0d d=%h m=%0d expected v=1 lat=3 d=%h m=%0d", i, got, lat, d, mis, ed, em); end
    end
  endtask

  task automatic test_reset_in_wait();
    bit got, mis; logic [31:0] d; int lat, ns;
    access(2, 1, Bundle::MT_W, 32'h200, 32'h11111111, 0, got, d, mis, lat, ns);
    n_cmp++; if (!got || lat != 4 || ns != 4) begin
      n_err++; $display("FAIL w3_write: got v=%0d lat=%0d stall=%0d expected v=1 lat=4 stall=4", got, lat, ns); end
    @(posedge clk); #1;
    req_valid[2] = 1; req_fcn[2] = 1; req_typ[2] = Bundle::MT_W;
    req_addr[2] = 32'h200; req_data[2] = 32'hAAAAAAAA;
    @(posedge clk); #1;
    req_valid[2] = 0;
    n_cmp++; if (stall[2] !== 1'b1) begin n_err++; $display("FAIL w3_in_wait: got stall=%b expected 1", stall[2]); end
    #2 rst_v[2] = 1'b1;
    #1;
    n_cmp++; if (stall[2] !== 1'b0 || res_valid[2] !== 1'b0) begin
      n_err++; $display("FAIL w3_reset_now: got stall=%b v=%b expected stall=0 v=0", stall[2], res_valid[2]); end
    repeat (4) @(posedge clk);
    #3 rst_v[2] = 1'b0;
    access(2, 0, Bundle::MT_W, 32'h200, 32'h0, 0, got, d, mis, lat, ns);
    n_cmp++; if (!got || d !== 32'h11111111) begin
      n_err++; $display("FAIL w3_no_write: got v=%0d d=%h expected v=1 d=11111111", got, d); end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_subword();
    test_partial_write();
    test_misaligned();
    test_wrap();
    test_back_to_back();
    test_wait_states();
    test_overlap();
    test_wait_random();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
